// File: rtl/mmio_capture.sv
// Snoops core word stores into a 16-byte MMIO window and queues them in a first-word fall-through FIFO.
// Capture latency: one cycle. A push into a full FIFO with no pop is dropped and counted; the drop counter saturates at 255.
module mmio_capture #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [31:0]                DataAdr,
    input  logic [31:0]                WriteData,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [1:0]                 out_offset,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [33:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;
    logic [7:0]    drop_q;

    logic       hit, push_req, ctrl_clr, pop, is_full, push, drop;
    logic [1:0] off;

    assign off      = DataAdr[3:2];
    assign hit      = MemWrite && (DataAdr[31:4] == BASE_ADDR[31:4]) && (DataAdr[1:0] == 2'b00);
    assign push_req = hit && (off != 2'd3);
    assign ctrl_clr = hit && (off == 2'd3) && WriteData[0];
    assign is_full  = (count_q == CW'(DEPTH));
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push     = push_req && (!is_full || pop);
    assign drop     = push_req && is_full && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {off, WriteData};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            count_q <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (ctrl_clr) begin
                overflow_q <= 1'b0;
                drop_q     <= 8'd0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hFF)
                    drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[rd_ptr_q][31:0];
    assign out_offset = mem_q[rd_ptr_q][33:32];
    assign count      = count_q;
    assign full       = is_full;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_mmio_capture.sv
// Directed bench for mmio_capture: inputs driven on the falling edge, outputs checked on the following falling edge.
module tb_mmio_capture;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_offset;
    logic [3:0]  count;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_err = 0;

    mmio_capture #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_offset(out_offset), .count(count), .full(full),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Called on a falling edge; presents one store for the next rising edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        out_ready = rdy;
        @(negedge clk);
        MemWrite  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic cyc(input logic rdy);
        out_ready = rdy;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_err++; $display("FAIL reset_ovf got %b/%0d want 0/0", overflow, drop_count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        store(BASE, 32'h41, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'h41) begin n_err++; $display("FAIL basic_data got %h want 41", out_data); end
        n_cmp++; if (out_offset !== 2'd0) begin n_err++; $display("FAIL basic_off got %0d want 0", out_offset); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL basic_count got %0d want 1", count); end
        cyc(1'b1);
        n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL basic_pop got %0d/%b want 0/0", count, out_valid); end
    endtask

    task automatic test_ignored;
        store(BASE + 32'd1, 32'h11, 1'b0);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ign_misaligned got %0d want 0", count); end
        store(BASE + 32'd16, 32'h22, 1'b0);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ign_outside got %0d want 0", count); end
        MemWrite = 1'b0; DataAdr = BASE; WriteData = 32'h33;
        cyc(1'b0);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL ign_nowrite got %0d want 0", count); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 10; i++) begin
            store(BASE + 32'((i - 1) % 3) * 32'd4, 32'(i), 1'b0);
            if (i == 8) begin
                n_cmp++; if (full !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL ovf_full got %b/%0d want 1/8", full, count); end
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", overflow); end
            end
        end
        n_cmp++; if (drop_count !== 8'd2) begin n_err++; $display("FAIL ovf_drops got %0d want 2", drop_count); end
        n_cmp++; if (overflow !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL ovf_flag got %b/%0d want 1/8", overflow, count); end
    endtask

    task automatic test_ctrl_clear;
        store(BASE + 32'd12, 32'h1, 1'b0);
        n_cmp++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_err++; $display("FAIL clr_flags got %b/%0d want 0/0", overflow, drop_count); end
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL clr_count got %0d want 8", count); end
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) || out_offset !== 2'((i - 1) % 3)) begin
                n_err++;
                $display("FAIL drain_%0d got v=%b d=%h o=%0d want v=1 d=%h o=%0d", i, out_valid, out_data, out_offset, i, (i - 1) % 3);
            end
            cyc(1'b1);
        end
        n_cmp++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %0d/%b want 0/0", count, out_valid); end
    endtask

    task automatic test_full_push_pop;
        for (int i = 1; i <= 8; i++) store(BASE, 32'h100 + 32'(i), 1'b0);
        store(BASE + 32'd4, 32'hAA, 1'b1);
        n_cmp++; if (count !== 4'd8 || drop_count !== 8'd0) begin n_err++; $display("FAIL fpp_count got %0d/%0d want 8/0", count, drop_count); end
        n_cmp++; if (out_data !== 32'h102) begin n_err++; $display("FAIL fpp_head got %h want 102", out_data); end
        for (int i = 0; i < 7; i++) cyc(1'b1);
        n_cmp++; if (out_data !== 32'hAA || out_offset !== 2'd1 || count !== 4'd1) begin n_err++; $display("FAIL fpp_last got %h/%0d/%0d want aa/1/1", out_data, out_offset, count); end
        cyc(1'b1);
    endtask

    task automatic test_back_to_back;
        store(BASE, 32'hB1, 1'b1);
        n_cmp++; if (count !== 4'd1 || out_data !== 32'hB1) begin n_err++; $display("FAIL b2b_first got %0d/%h want 1/b1", count, out_data); end
        for (int i = 2; i <= 4; i++) store(BASE + 32'd8, 32'hB0 + 32'(i), 1'b1);
        n_cmp++; if (count !== 4'd1 || out_data !== 32'hB4 || out_offset !== 2'd2) begin n_err++; $display("FAIL b2b_stream got %0d/%h/%0d want 1/b4/2", count, out_data, out_offset); end
        cyc(1'b1);
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL b2b_empty got %0d want 0", count); end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 8; i++) store(BASE, 32'(i), 1'b0);
        for (int i = 0; i < 300; i++) store(BASE + 32'd4, 32'hDEAD, 1'b0);
        n_cmp++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin n_err++; $display("FAIL sat_drops got %0d/%b want 255/1", drop_count, overflow); end
        n_cmp++; if (count !== 4'd8 || out_data !== 32'd0) begin n_err++; $display("FAIL sat_fifo got %0d/%h want 8/0", count, out_data); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) cyc(1'b1);
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL ares_pre got %0d want 5", count); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL ares_now got %b/%0d want 0/0", out_valid, count); end
        n_cmp++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_err++; $display("FAIL ares_ovf got %b/%0d want 0/0", overflow, drop_count); end
        #1 reset = 1'b0;
        @(negedge clk);
        store(BASE + 32'd8, 32'h55, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h55 || out_offset !== 2'd2 || count !== 4'd1) begin n_err++; $display("FAIL ares_post got %b/%h/%0d/%0d want 1/55/2/1", out_valid, out_data, out_offset, count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored();
        test_overflow();
        test_ctrl_clear();
        test_drain();
        test_full_push_pop();
        test_back_to_back();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_capture.md
# mmio_capture

Memory-mapped store-capture buffer on the processor's data-memory bus, downstream of the ARM core alongside `dmem`. It snoops the `MemWrite`/`DataAdr`/`WriteData` store port and captures word stores that hit a small MMIO window into a FIFO. The FIFO drains through a valid/ready stream to a console/trace consumer. Overflow is reported through a sticky flag and a saturating drop counter, both clearable by a control store from software.

## Interface

Parameters:
- `BASE_ADDR`, default 32'hFFFF_0000: 16-byte-aligned base of the MMIO window.
- `DEPTH`, default 8: FIFO entries. Power of two, ≥2.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `MemWrite` in 1: store strobe from the core.
- `DataAdr` in 32: store address from the core.
- `WriteData` in 32: store data from the core.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out 32: head data word.
- `out_offset` out 2: word offset within the window of the head entry (0–2).
- `count` out $clog2(DEPTH)+1: current occupancy.
- `full` out 1: `count == DEPTH`.
- `overflow` out 1: sticky; a capture was dropped.
- `drop_count` out 8: dropped captures, saturating at 255.

## Operation

- Hit: `MemWrite && DataAdr[31:4] == BASE_ADDR[31:4] && DataAdr[1:0] == 0`. Misaligned or out-of-window stores are ignored.
- Word offset `off = DataAdr[3:2]`.
  - `off` 0–2: data push. Entry is `{off, WriteData}`.
  - `off` 3: control store, never enqueued. `WriteData[0]=1` clears `overflow` and `drop_count`. Other bits are ignored.
- Pop: `out_valid && out_ready`.
- FIFO is first-word fall-through:
  - `out_valid = (count != 0)`.
  - `out_data`/`out_offset` are driven combinationally from the storage entry at the read pointer.
  - `out_data`/`out_offset` are don't-care when `out_valid=0`.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately.
- Push/pop resolution per cycle:
  - Push, no pop, not full: write the entry, advance the write pointer, `count+1`.
  - Pop, no push: advance the read pointer, `count-1`.
  - Push and pop, count ≥1: both happen, `count` unchanged. This includes the full case: the push is accepted because the slot is freed the same edge.
  - Push when empty, with `out_ready=1`: push only. The new entry is not popped that cycle because `out_valid` was 0.
  - Push when full with no pop: entry dropped, `overflow←1`, `drop_count←min(drop_count+1,255)`. FIFO contents are unchanged.
- Dropped stores and control stores cannot coincide, because only one store occurs per cycle.
- `out_ready` while `out_valid=0` has no effect.

## Timing

- Reset values, applied asynchronously and immediately on `reset` assertion:
  - write/read pointers = 0, `count` = 0.
  - `out_valid` = 0, `full` = 0, `overflow` = 0, `drop_count` = 0.
  - Storage RAM is not reset.
- Reset mid-operation discards all queued entries. `out_valid` drops in the same cycle, without waiting for a clock edge.
- Capture latency: a store sampled at edge N gives `out_valid=1` with that entry at the head in the cycle after edge N. This assumes the FIFO was empty.
- A pop at edge N presents the next entry in the cycle after N.
- `full`, `count`, `overflow`, and `drop_count` update at the same edge as the event that causes them.
- A control clear takes effect at the edge that samples the control store.
- Throughput: one push and one pop per cycle sustained.

## Test plan

1. Reset, then store 32'h0000_0041 to BASE+0 with `out_ready=0`.
   - Next cycle: `out_valid=1`, `out_data=32'h41`, `out_offset=0`, `count=1`.
   - Raise `out_ready` for one cycle: `count=0`, `out_valid=0`.
2. Ignored stores: misaligned BASE+1, out-of-window BASE+16, and `MemWrite=0` with BASE+0. Each must leave `count=0`.
3. With `out_ready=0`, store to BASE+0/4/8 cyclically, 10 times with data 1..10.
   - After the 8th store: `full=1`.
   - After the 10th: `drop_count=2`, `overflow=1`.
   - Draining yields data 1..8 with offsets 0,1,2,0,1,2,0,1.
4. Full FIFO, same cycle push of 32'hAA and `out_ready=1`: `count` stays 8, `drop_count` unchanged. 32'hAA appears as the last drained word.
5. After scenario 3, store 32'h1 to BASE+12: `overflow=0`, `drop_count=0`, `count` unchanged. Saturation check: 300 drops while full leave `drop_count=255`.
6. Assert `reset` asynchronously mid-stream (between edges) with `count=5`: `out_valid`, `count`, and `overflow` read 0 before the next edge. The first post-reset capture appears at the head.
